multicycle_control_unit: RTL and testbench

Multi-cycle sequencer for the 8-bit processor datapath. It fetches from the instruction memory, latches the 2-bit opcode, and steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives every datapath enable: PC, IR, register file, ALU source and data memory. It also provides run, single-step and halt control, and flags any fetch beyond the instruction-memory limit.

---
 rtl/cpu_ctrl_pkg.sv | 38 +++
 rtl/control_decoder.sv | 47 ++++
 rtl/multicycle_control_unit.sv | 134 +++++++++++++
 tb/tb_multicycle_control_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, opcodes
// and bit positions inside the control word.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } ctrlState_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } opcode_t;

  localparam int unsigned CW_IR_LOAD         = 0;
  localparam int unsigned CW_PC_WRITE        = 1;
  localparam int unsigned CW_PC_SRC          = 2;
  localparam int unsigned CW_REG_WRITE       = 3;
  localparam int unsigned CW_REG_DST         = 4;
  localparam int unsigned CW_ALU_SRC         = 5;
  localparam int unsigned CW_MEM_READ        = 6;
  localparam int unsigned CW_MEM_WRITE       = 7;
  localparam int unsigned CW_MEM_TO_REG      = 8;
  localparam int unsigned CW_RETIRED         = 9;
  // SW retires in whichever MEM cycle sees mem_ready; the decoder only
  // marks the candidate, the top qualifies it with mem_ready.
  localparam int unsigned CW_RETIRE_ON_READY = 10;
  localparam int unsigned CW_WIDTH           = 11;

  typedef logic [CW_WIDTH-1:0] ctrlWord_t;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational map from (state, latched opcode) to the control word.
module control_decoder
  import cpu_ctrl_pkg::*;
(
  input  ctrlState_t state,
  input  opcode_t    opcode,
  output ctrlWord_t  ctrlWord
);

  // Moore decode of every datapath strobe
  always_comb begin
    ctrlWord = '0;
    case (state)
      ST_FETCH: begin
        ctrlWord[CW_IR_LOAD]  = 1'b1;
        ctrlWord[CW_PC_WRITE] = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_LW, OP_SW: ctrlWord[CW_ALU_SRC] = 1'b1;
          OP_J: begin
            ctrlWord[CW_PC_WRITE] = 1'b1;
            ctrlWord[CW_PC_SRC]   = 1'b1;
            ctrlWord[CW_RETIRED]  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (opcode == OP_LW) begin
          ctrlWord[CW_MEM_READ] = 1'b1;
        end else if (opcode == OP_SW) begin
          ctrlWord[CW_MEM_WRITE]       = 1'b1;
          ctrlWord[CW_RETIRE_ON_READY] = 1'b1;
        end
      end
      ST_WB: begin
        ctrlWord[CW_REG_WRITE]  = 1'b1;
        ctrlWord[CW_RETIRED]    = 1'b1;
        ctrlWord[CW_REG_DST]    = (opcode == OP_ADD);
        ctrlWord[CW_MEM_TO_REG] = (opcode == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FSM, opcode latch, step/halt handling, sticky
// fetch-range fault and retired-instruction counter.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned HIGHER_IMEM_LIMIT = 255,
  parameter int unsigned COUNT_W           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic [7:0]         instruction,
  input  logic [7:0]         pc,
  input  logic               mem_ready,
  output logic               ir_load,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               retired,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  ctrlState_t stateReg;
  ctrlState_t nextState;
  opcode_t    opcodeReg;
  ctrlWord_t  ctrlWord;
  logic       stepMode;
  logic       faultReg;
  logic       fetchOutOfRange;
  logic       strobeEn;
  logic       retire;
  logic       unusedInstrBits;

  assign fetchOutOfRange = 32'(pc) > HIGHER_IMEM_LIMIT;
  assign unusedInstrBits = ^instruction[5:0];

  // A fault fetch and a reset cycle both suppress every strobe
  assign strobeEn = ~reset & ~((stateReg == ST_FETCH) & fetchOutOfRange);
  assign retire   = strobeEn & (ctrlWord[CW_RETIRED] |
                                (ctrlWord[CW_RETIRE_ON_READY] & mem_ready));

  control_decoder uDecoder (
    .state    (stateReg),
    .opcode   (opcodeReg),
    .ctrlWord (ctrlWord)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= ST_IDLE;
    end else begin
      stateReg <= nextState;
    end
  end

  // Next-state logic; boundary decides IDLE vs back-to-back FETCH
  always_comb begin
    ctrlState_t boundary;
    boundary  = (halt_req || stepMode || !run) ? ST_IDLE : ST_FETCH;
    nextState = stateReg;
    case (stateReg)
      ST_IDLE:   if (!faultReg && (run || step)) nextState = ST_FETCH;
      ST_FETCH:  nextState = fetchOutOfRange ? ST_IDLE : ST_DECODE;
      ST_DECODE: nextState = ST_EXEC;
      ST_EXEC: begin
        case (opcodeReg)
          OP_ADD:       nextState = ST_WB;
          OP_LW, OP_SW: nextState = ST_MEM;
          default:      nextState = boundary;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) nextState = (opcodeReg == OP_SW) ? boundary : ST_WB;
      end
      ST_WB:     nextState = boundary;
      default:   nextState = ST_IDLE;
    endcase
  end

  // Output decode, gated so nothing fires during reset or a faulting fetch
  always_comb begin
    ir_load    = strobeEn & ctrlWord[CW_IR_LOAD];
    pc_write   = strobeEn & ctrlWord[CW_PC_WRITE];
    pc_src     = strobeEn & ctrlWord[CW_PC_SRC];
    reg_write  = strobeEn & ctrlWord[CW_REG_WRITE];
    reg_dst    = strobeEn & ctrlWord[CW_REG_DST];
    alu_src    = strobeEn & ctrlWord[CW_ALU_SRC];
    mem_read   = strobeEn & ctrlWord[CW_MEM_READ];
    mem_write  = strobeEn & ctrlWord[CW_MEM_WRITE];
    mem_to_reg = strobeEn & ctrlWord[CW_MEM_TO_REG];
    retired    = retire;
    halted     = (stateReg == ST_IDLE);
    fault      = faultReg;
    state      = stateReg;
  end

  // Opcode latch, step flag, sticky fault and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      opcodeReg   <= OP_ADD;
      stepMode    <= 1'b0;
      faultReg    <= 1'b0;
      instr_count <= '0;
    end else begin
      if (stateReg == ST_IDLE && nextState == ST_FETCH) begin
        stepMode <= step;
      end else if (retire) begin
        stepMode <= 1'b0;
      end
      if (stateReg == ST_FETCH) begin
        if (fetchOutOfRange) begin
          faultReg <= 1'b1;
        end else begin
          opcodeReg <= opcode_t'(instruction[7:6]);
        end
      end
      if (retire) begin
        instr_count <= instr_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed table, hand sequences and randomized
// instruction streams checked against a per-instruction cycle-schedule model.
module tb_multicycle_control_unit;

  localparam logic [7:0] LIMIT8 = 8'd4;

  localparam logic [2:0] SIDLE = 3'd0, SFETCH = 3'd1, SDEC = 3'd2,
                         SEXEC = 3'd3, SMEM = 3'd4, SWB = 3'd5;

  // strobe vector: {ir_load,pc_write,pc_src,reg_write,reg_dst,alu_src,
  //                 mem_read,mem_write,mem_to_reg,retired}
  localparam logic [9:0] IRL = 10'h200, PCW = 10'h100, PCS = 10'h080,
                         RGW = 10'h040, RDS = 10'h020, ALS = 10'h010,
                         MRD = 10'h008, MWR = 10'h004, M2R = 10'h002,
                         RET = 10'h001;

  typedef struct {
    logic [2:0] st;
    logic [9:0] cw;
    bit         fs;
  } exp_t;

  typedef struct {
    logic [7:0]  instr;
    int unsigned waits;
    int unsigned retireAt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, run = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic [7:0]  instruction = '0, pc = '0;
  logic        mem_ready = 1'b0;
  logic        ir_load, pc_write, pc_src, reg_write, reg_dst, alu_src;
  logic        mem_read, mem_write, mem_to_reg, retired, halted, fault;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic [7:0]  imem [256];
  logic [7:0]  ir = '0, irNext = '0, pcNext = '0;
  logic [15:0] expCount = '0;
  logic        expFault = 1'b0;
  int unsigned cycNo = 0, lastRetire = 0, jumps = 0;
  int unsigned tests = 0, fails = 0;

  multicycle_control_unit #(
    .HIGHER_IMEM_LIMIT (4),
    .COUNT_W           (16)
  ) dut (
    .clk (clk), .reset (reset), .run (run), .step (step),
    .halt_req (halt_req), .instruction (instruction), .pc (pc),
    .mem_ready (mem_ready), .ir_load (ir_load), .pc_write (pc_write),
    .pc_src (pc_src), .reg_write (reg_write), .reg_dst (reg_dst),
    .alu_src (alu_src), .mem_read (mem_read), .mem_write (mem_write),
    .mem_to_reg (mem_to_reg), .retired (retired), .halted (halted),
    .fault (fault), .state (state), .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic [2:0] s, input logic [9:0] c, input bit f = 1'b0);
    exp_t e;
    e.st = s; e.cw = c; e.fs = f;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycNo, act, expv);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, compare, then
  // advance the bench-side datapath (pc / ir registers) for the next edge.
  task automatic cyc(input logic rst, input logic rn, input logic st, input logic hr,
                     input logic mr, input exp_t e, input bit chk);
    @(negedge clk);
    pc = pcNext; ir = irNext;
    instruction = imem[pc];
    reset = rst; run = rn; step = st; halt_req = hr; mem_ready = mr;
    #1;
    cycNo++;
    if (chk) begin
      check("ctrl", 32'({state, ir_load, pc_write, pc_src, reg_write, reg_dst, alu_src,
                         mem_read, mem_write, mem_to_reg, retired}), 32'({e.st, e.cw}));
      check("halted", 32'(halted), 32'(e.st == SIDLE));
      check("fault", 32'(fault), 32'(expFault));
      check("instr_count", 32'(instr_count), 32'(expCount));
    end
    if (retired) lastRetire = cycNo;
    if (pc_write && pc_src) jumps++;
    if (rst) begin
      pcNext = '0; expCount = '0; expFault = 1'b0;
    end else begin
      if (pc_write) pcNext = pc_src ? {pc[7:6], ir[5:0]} : pc + 8'd1;
      if (ir_load) irNext = instruction;
      if ((e.cw & RET) != 10'd0) expCount = expCount + 16'd1;
      if (e.fs) expFault = 1'b1;
    end
  endtask

  task automatic idle(input logic rn, input logic st);
    cyc(1'b0, rn, st, 1'b0, rbit(), mk(SIDLE, 10'd0), 1'b1);
  endtask

  // Reset for two cycles with run high; the second cycle is checked.
  task automatic doReset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(SIDLE, 10'd0), 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(SIDLE, 10'd0), 1'b1);
  endtask

  task automatic clearMem();
    for (int a = 0; a < 256; a++) imem[a] = 8'h00;
  endtask

  // Model of one instruction starting in FETCH: schedule follows the
  // opcode's latency, stretched by w not-ready MEM cycles.
  task automatic runInstr(input int unsigned w, input bit h, input logic rn,
                          input bit stepMode, input bit stepInExec,
                          output bit faulted, output bit toIdle);
    logic [7:0] p;
    logic [1:0] op;
    p = pcNext;
    faulted = 1'b0;
    toIdle = 1'b1;
    if (p > LIMIT8) begin
      cyc(1'b0, rn, 1'b0, 1'b0, rbit(), mk(SFETCH, 10'd0, 1'b1), 1'b1);
      faulted = 1'b1;
      return;
    end
    op = imem[p][7:6];
    cyc(1'b0, rn, 1'b0, 1'b0, rbit(), mk(SFETCH, IRL | PCW), 1'b1);
    cyc(1'b0, rn, 1'b0, h, rbit(), mk(SDEC, 10'd0), 1'b1);
    case (op)
      2'b00: begin
        cyc(1'b0, rn, stepInExec, h, rbit(), mk(SEXEC, 10'd0), 1'b1);
        cyc(1'b0, rn, 1'b0, h, rbit(), mk(SWB, RGW | RDS | RET), 1'b1);
      end
      2'b01: begin
        cyc(1'b0, rn, stepInExec, h, rbit(), mk(SEXEC, ALS), 1'b1);
        for (int unsigned i = 0; i < w; i++)
          cyc(1'b0, rn, 1'b0, h, 1'b0, mk(SMEM, MRD), 1'b1);
        cyc(1'b0, rn, 1'b0, h, 1'b1, mk(SMEM, MRD), 1'b1);
        cyc(1'b0, rn, 1'b0, h, rbit(), mk(SWB, RGW | M2R | RET), 1'b1);
      end
      2'b10: begin
        cyc(1'b0, rn, stepInExec, h, rbit(), mk(SEXEC, ALS), 1'b1);
        for (int unsigned i = 0; i < w; i++)
          cyc(1'b0, rn, 1'b0, h, 1'b0, mk(SMEM, MWR), 1'b1);
        cyc(1'b0, rn, 1'b0, h, 1'b1, mk(SMEM, MWR | RET), 1'b1);
      end
      default: begin
        cyc(1'b0, rn, stepInExec, h, rbit(), mk(SEXEC, PCW | PCS | RET), 1'b1);
      end
    endcase
    toIdle = h || !rn || stepMode;
  endtask

  initial begin
    vec_t        tbl [5];
    bit          flt, ti;
    int unsigned base;

    tbl[0] = '{8'h44, 0, 5};
    tbl[1] = '{8'h49, 0, 10};
    tbl[2] = '{8'h18, 0, 14};
    tbl[3] = '{8'h89, 0, 18};
    tbl[4] = '{8'hC3, 0, 21};

    // Reset state, then the five-instruction program back to back
    clearMem();
    for (int i = 0; i < 5; i++) imem[i] = tbl[i].instr;
    doReset();
    idle(1'b1, 1'b0);
    base = cycNo;
    jumps = 0;
    for (int i = 0; i < 5; i++) begin
      runInstr(tbl[i].waits, 1'b0, (i != 4), 1'b0, 1'b0, flt, ti);
      check("retire_cycle", 32'(lastRetire - base), 32'(tbl[i].retireAt));
    end
    idle(1'b0, 1'b0);
    check("jump_count", 32'(jumps), 32'd1);
    check("program_count", 32'(instr_count), 32'd5);

    // LW with mem_ready low for three cycles
    clearMem();
    imem[0] = 8'h44;
    doReset();
    idle(1'b1, 1'b0);
    base = cycNo;
    runInstr(3, 1'b0, 1'b0, 1'b0, 1'b0, flt, ti);
    check("lw_wait_latency", 32'(lastRetire - base), 32'd8);
    idle(1'b0, 1'b0);

    // Single step of an ADD with run low; extra step in EXEC is ignored
    clearMem();
    doReset();
    idle(1'b0, 1'b1);
    runInstr(0, 1'b0, 1'b0, 1'b1, 1'b1, flt, ti);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("step_count", 32'(instr_count), 32'd1);

    // halt_req from DECODE: the ADD still writes back, then IDLE
    clearMem();
    doReset();
    idle(1'b1, 1'b0);
    runInstr(0, 1'b1, 1'b1, 1'b0, 1'b0, flt, ti);
    idle(1'b0, 1'b0);
    check("halt_count", 32'(instr_count), 32'd1);

    // Reset during WB of a LW: no write strobe in that cycle, no retire
    clearMem();
    imem[0] = 8'h44;
    doReset();
    idle(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(SFETCH, IRL | PCW), 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(SDEC, 10'd0), 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(SEXEC, ALS), 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, mk(SMEM, MRD), 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mk(SWB, 10'd0), 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mk(SIDLE, 10'd0), 1'b1);

    // Run off the end of the legal range: fault at pc 5, sticky until reset
    clearMem();
    doReset();
    idle(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      runInstr(0, 1'b0, 1'b1, 1'b0, 1'b0, flt, ti);
      if (flt) break;
    end
    check("fault_reached", 32'(flt), 32'd1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    doReset();
    check("fault_cleared", 32'(fault), 32'd0);

    // Randomized streams: random opcodes, waits and halts until a fault
    for (int ep = 0; ep < 20; ep++) begin
      for (int a = 0; a < 256; a++) begin
        logic [1:0] op;
        op = 2'($urandom_range(0, 3));
        if (op == 2'b11) imem[a] = {2'b11, 6'($urandom_range(0, 4))};
        else             imem[a] = {op, 6'($urandom)};
      end
      doReset();
      idle(1'b1, 1'b0);
      for (int k = 0; k < 15; k++) begin
        runInstr($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b1,
                 1'b0, 1'b0, flt, ti);
        if (flt) begin
          idle(1'b1, 1'b1);
          break;
        end
        if (ti) idle(1'b1, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
